// File: rtl/sliding_win_sum_if.sv
// Sample/result bundle for sliding_win_sum. The master drives samples and clear.
// The slave, which is the summing block, drives the window sum and status.
interface sliding_win_sum_if #(
  parameter int DW   = 8,
  parameter int GBIT = 6
);
  logic                 clr;
  logic                 in_valid;
  logic [DW-1:0]        in_re;
  logic [DW-1:0]        in_im;
  logic                 out_valid;
  logic [DW+GBIT-1:0]   sum_re;
  logic [DW+GBIT-1:0]   sum_im;
  logic                 full;

  modport master (
    output clr, in_valid, in_re, in_im,
    input  out_valid, sum_re, sum_im, full
  );

  modport slave (
    input  clr, in_valid, in_re, in_im,
    output out_valid, sum_re, sum_im, full
  );
endinterface

// File: rtl/sliding_win_sum.sv
// Complex sliding-window sum of the last WIN accepted samples, with an internal
// circular delay line, fill tracking, synchronous clear and two-edge latency.
module sliding_win_sum #(
  parameter int DW   = 8,
  parameter int WIN  = 64,
  parameter int AW   = 6,
  parameter int GBIT = 6
) (
  input  logic            clk,
  input  logic            rst,
  sliding_win_sum_if.slave bus
);
  localparam int SW = DW + GBIT;
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_FILL,
    ST_FULL
  } fill_state_e;

  fill_state_e          state_q, state_d;
  logic [CW-1:0]        count_q, count_d;
  logic [AW-1:0]        wp_q, wp_d;
  logic                 accept;

  logic [2*DW-1:0]      mem [WIN];
  logic [2*DW-1:0]      rd_data;

  logic                 s1_vld_q;
  logic                 s1_old_vld_q;
  logic [DW-1:0]        s1_new_re_q, s1_new_im_q;
  logic [DW-1:0]        s1_old_re_q, s1_old_im_q;

  logic signed [SW-1:0] sum_re_q, sum_re_d;
  logic signed [SW-1:0] sum_im_q, sum_im_d;
  logic                 out_valid_q, out_valid_d;
  logic                 full_q, full_d;

  function automatic logic signed [SW-1:0] sext(input logic [DW-1:0] x);
    return {{GBIT{x[DW-1]}}, x};
  endfunction

  assign accept  = bus.in_valid & ~bus.clr;
  assign rd_data = mem[wp_q];

  // NOTE: the delay line is never reset; stale entries are harmless because the
  // fill state masks the subtraction until WIN fresh samples have been written.
  always_ff @(posedge clk) begin
    if (accept) mem[wp_q] <= {bus.in_re, bus.in_im};
  end

  // NOTE: every variable gets its hold value before any branch, so no path
  // through this block leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    wp_d    = wp_q;
    if (bus.clr) begin
      state_d = ST_EMPTY;
      count_d = '0;
      wp_d    = '0;
    end else if (bus.in_valid) begin
      wp_d = (wp_q == AW'(WIN - 1)) ? '0 : wp_q + AW'(1);
      unique case (state_q)
        ST_EMPTY: begin
          state_d = ST_FILL;
          count_d = CW'(1);
        end
        ST_FILL: begin
          count_d = count_q + CW'(1);
          if (count_q == CW'(WIN - 1)) state_d = ST_FULL;
        end
        ST_FULL:  count_d = CW'(WIN);
        default:  state_d = ST_EMPTY;
      endcase
    end
  end

  // NOTE: all registers use <= so each one samples pre-edge values regardless
  // of statement order within the block.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_EMPTY;
      count_q <= '0;
      wp_q    <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      wp_q    <= wp_d;
    end
  end

  // Stage 1: the old sample only counts once the window was already full.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_vld_q     <= 1'b0;
      s1_old_vld_q <= 1'b0;
      s1_new_re_q  <= '0;
      s1_new_im_q  <= '0;
      s1_old_re_q  <= '0;
      s1_old_im_q  <= '0;
    end else begin
      s1_vld_q <= accept;
      if (accept) begin
        s1_old_vld_q <= (state_q == ST_FULL);
        s1_new_re_q  <= bus.in_re;
        s1_new_im_q  <= bus.in_im;
        s1_old_re_q  <= rd_data[2*DW-1:DW];
        s1_old_im_q  <= rd_data[DW-1:0];
      end
    end
  end

  always_comb begin
    sum_re_d    = sum_re_q;
    sum_im_d    = sum_im_q;
    out_valid_d = 1'b0;
    full_d      = (state_q == ST_FULL) & ~bus.clr;
    if (bus.clr) begin
      sum_re_d = '0;
      sum_im_d = '0;
    end else if (s1_vld_q) begin
      sum_re_d    = sum_re_q + sext(s1_new_re_q)
                    - (s1_old_vld_q ? sext(s1_old_re_q) : SW'(0));
      sum_im_d    = sum_im_q + sext(s1_new_im_q)
                    - (s1_old_vld_q ? sext(s1_old_im_q) : SW'(0));
      out_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sum_re_q    <= '0;
      sum_im_q    <= '0;
      out_valid_q <= 1'b0;
      full_q      <= 1'b0;
    end else begin
      sum_re_q    <= sum_re_d;
      sum_im_q    <= sum_im_d;
      out_valid_q <= out_valid_d;
      full_q      <= full_d;
    end
  end

  assign bus.sum_re    = sum_re_q;
  assign bus.sum_im    = sum_im_q;
  assign bus.out_valid = out_valid_q;
  assign bus.full      = full_q;
endmodule

// File: tb/tb_sliding_win_sum.sv
// Self-checking bench for sliding_win_sum: a vector table, directed corner
// sequences and a gapped random run against a queue-based window model.
module tb_sliding_win_sum;
  localparam int DW   = 8;
  localparam int WIN  = 64;
  localparam int AW   = 6;
  localparam int GBIT = 6;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  sliding_win_sum_if #(.DW(DW), .GBIT(GBIT)) bus ();

  sliding_win_sum #(.DW(DW), .WIN(WIN), .AW(AW), .GBIT(GBIT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  // Model: committed window contents plus one accepted sample not yet visible.
  int  m_re[$];
  int  m_im[$];
  int  m_cnt;
  bit  p_v;
  int  p_re, p_im;
  bit  e_ov;

  function automatic void model_clear();
    m_re.delete();
    m_im.delete();
    m_cnt = 0;
    p_v   = 1'b0;
    e_ov  = 1'b0;
  endfunction

  function automatic void model_edge(input bit v, input bit c, input int re, input int im);
    if (!rst || c) begin
      model_clear();
    end else begin
      e_ov = p_v;
      if (p_v) begin
        m_re.push_back(p_re);
        m_im.push_back(p_im);
        if (m_re.size() > WIN) begin
          m_re.delete(0);
          m_im.delete(0);
        end
        if (m_cnt < WIN) m_cnt++;
      end
      p_v  = v;
      p_re = re;
      p_im = im;
    end
  endfunction

  function automatic longint win_sum(input bit imag);
    longint s = 0;
    for (int i = 0; i < m_re.size(); i++) s += imag ? m_im[i] : m_re[i];
    return s;
  endfunction

  function automatic longint dut_re();
    return longint'($signed(bus.sum_re));
  endfunction

  function automatic longint dut_im();
    return longint'($signed(bus.sum_im));
  endfunction

  task automatic compare_model();
    check("model out_valid", longint'(bus.out_valid), longint'(e_ov));
    check("model full", longint'(bus.full), longint'(m_cnt >= WIN));
    check("model sum_re", dut_re(), win_sum(1'b0));
    check("model sum_im", dut_im(), win_sum(1'b1));
  endtask

  task automatic tick(input bit v, input bit c, input int re, input int im);
    logic [31:0] r, q;
    r = re;
    q = im;
    bus.in_valid = v;
    bus.clr      = c;
    bus.in_re    = r[DW-1:0];
    bus.in_im    = q[DW-1:0];
    @(posedge clk);
    model_edge(v, c, re, im);
    #1;
    compare_model();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 0, 0);
  endtask

  task automatic async_reset_pulse();
    #2 rst = 1'b0;
    model_clear();
    #1;
    compare_model();
    check("async rst out_valid", longint'(bus.out_valid), 0);
    #2 rst = 1'b1;
  endtask

  typedef struct {
    bit v;
    bit c;
    int re;
    int im;
    bit ov;
    int s_re;
    int s_im;
    bit full;
  } vec_t;

  vec_t tbl[8];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1);
  end

  initial begin
    int pulses;
    int acc;

    tbl[0] = '{1'b1, 1'b0,   3,  -2, 1'b0, 0,  0, 1'b0};
    tbl[1] = '{1'b1, 1'b0,   5,   7, 1'b1, 3, -2, 1'b0};
    tbl[2] = '{1'b0, 1'b0,   0,   0, 1'b1, 8,  5, 1'b0};
    tbl[3] = '{1'b0, 1'b0,   0,   0, 1'b0, 8,  5, 1'b0};
    tbl[4] = '{1'b1, 1'b0, -10,   1, 1'b0, 8,  5, 1'b0};
    tbl[5] = '{1'b1, 1'b1,   9,   9, 1'b0, 0,  0, 1'b0};
    tbl[6] = '{1'b1, 1'b0,   4,   4, 1'b0, 0,  0, 1'b0};
    tbl[7] = '{1'b0, 1'b0,   0,   0, 1'b1, 4,  4, 1'b0};

    bus.clr = 1'b0; bus.in_valid = 1'b0; bus.in_re = '0; bus.in_im = '0;
    model_clear();

    // Reset held with live random inputs, then released with no traffic.
    for (int i = 0; i < 8; i++)
      tick(1'($urandom), 1'b0, int'($urandom_range(0, 255)) - 128,
           int'($urandom_range(0, 255)) - 128);
    check("reset sum_re", dut_re(), 0);
    rst = 1'b1;
    idle(4);
    check("post-reset out_valid", longint'(bus.out_valid), 0);

    // Vector table from a clean start.
    tick(1'b0, 1'b1, 0, 0);
    for (int i = 0; i < 8; i++) begin
      tick(tbl[i].v, tbl[i].c, tbl[i].re, tbl[i].im);
      check($sformatf("vec%0d out_valid", i), longint'(bus.out_valid), longint'(tbl[i].ov));
      check($sformatf("vec%0d sum_re", i), dut_re(), tbl[i].s_re);
      check($sformatf("vec%0d sum_im", i), dut_im(), tbl[i].s_im);
      check($sformatf("vec%0d full", i), longint'(bus.full), longint'(tbl[i].full));
    end

    // Constant ramp: 1 / -1 every cycle.
    tick(1'b0, 1'b1, 0, 0);
    pulses = 0;
    for (int i = 0; i < 100; i++) begin
      tick(1'b1, 1'b0, 1, -1);
      if (bus.out_valid) begin
        pulses++;
        check("ramp sum_re", dut_re(), (pulses < WIN) ? pulses : WIN);
        check("ramp sum_im", dut_im(), (pulses < WIN) ? -pulses : -WIN);
        check("ramp full", longint'(bus.full), longint'(pulses >= WIN));
      end
    end
    check("ramp pulse count", pulses, 99);

    // Impulse lives for exactly WIN pulses.
    tick(1'b0, 1'b1, 0, 0);
    tick(1'b1, 1'b0, 127, -128);
    pulses = 0;
    for (int i = 0; i < 80; i++) begin
      tick(1'b1, 1'b0, 0, 0);
      if (bus.out_valid) begin
        pulses++;
        check("impulse sum_re", dut_re(), (pulses <= WIN) ? 127 : 0);
        check("impulse sum_im", dut_im(), (pulses <= WIN) ? -128 : 0);
      end
    end

    // Full-scale negative then positive window.
    tick(1'b0, 1'b1, 0, 0);
    for (int i = 0; i < 70; i++) tick(1'b1, 1'b0, -128, 0);
    idle(2);
    check("fullscale neg sum_re", dut_re(), -8192);
    check("fullscale neg raw", longint'(bus.sum_re), 64'h2000);
    for (int i = 0; i < 64; i++) tick(1'b1, 1'b0, 127, 0);
    idle(2);
    check("fullscale pos sum_re", dut_re(), 8128);

    // Gapped random traffic at about 50% duty.
    tick(1'b0, 1'b1, 0, 0);
    acc = 0;
    for (int i = 0; i < 4000 && acc < 1000; i++) begin
      bit v;
      v = 1'($urandom);
      if (v) acc++;
      tick(v, 1'b0, int'($urandom_range(0, 255)) - 128,
           int'($urandom_range(0, 255)) - 128);
    end
    idle(3);
    check("random accepted count", acc, 1000);

    // Clear coinciding with a valid sample, then refill.
    tick(1'b0, 1'b1, 0, 0);
    for (int i = 0; i < 40; i++) tick(1'b1, 1'b0, 1, 0);
    tick(1'b1, 1'b1, 1, 0);
    check("clr sum_re", dut_re(), 0);
    check("clr full", longint'(bus.full), 0);
    tick(1'b0, 1'b0, 0, 0);
    check("after clr out_valid", longint'(bus.out_valid), 0);
    for (int i = 0; i < 64; i++) tick(1'b1, 1'b0, 2, 0);
    idle(2);
    check("refill after clr sum_re", dut_re(), 128);
    check("refill after clr full", longint'(bus.full), 1);

    // Same again with an asynchronous reset pulse mid-stream.
    for (int i = 0; i < 40; i++) tick(1'b1, 1'b0, 1, 0);
    async_reset_pulse();
    check("async rst sum_re", dut_re(), 0);
    check("async rst full", longint'(bus.full), 0);
    for (int i = 0; i < 64; i++) tick(1'b1, 1'b0, 2, 0);
    idle(2);
    check("refill after rst sum_re", dut_re(), 128);
    check("refill after rst full", longint'(bus.full), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
